ahb2apb_bridge_mp: RTL and testbench
====================================

# ahb2apb_bridge_mp

Parametrised AHB-to-APB3 bridge. It acts as one AHB slave and fans out to NUM_SLV APB3 slaves through a one-hot psel vector, with address decoding, pready wait-state support, pslverr propagation, and a pready timeout. All APB-side and hready/hresp/hrdata outputs come from registers. It replaces the fixed single-slave 32-bit bridge in the peripheral subsystem.

## Interface
- ADDR_W, 32, AHB/APB address width.
- DATA_W, 32, AHB/APB data width.
- NUM_SLV, 4, number of APB slaves (1..16). IDXW = max(1, clog2(NUM_SLV)).
- SLV_AW, 12, address bits per slave window (4 KB windows).
- BASE_ADDR, 32'h4000_0000, bridge base address; only bits [ADDR_W-1:SLV_AW+IDXW] are compared.
- TIMEOUT, 16, maximum ACCESS cycles with pready low before an error. 0 disables the timeout.
- hclk  in  1  the only clock; all logic on rising edge.
- hreset  in  1  synchronous, active-high reset.
- hsel, hwrite, hreadyin  in  1  AHB slave select, direction, and bus ready.
- htrans  in  2  AHB transfer type; NONSEQ/SEQ (htrans[1]=1) are valid.
- haddr  in  ADDR_W  AHB address.
- hwdata  in  DATA_W  AHB write data, valid in the cycle after the address phase.
- hready  out  1  transfer done / bridge ready.
- hresp  out  1  0=OKAY, 1=ERROR.
- hrdata  out  DATA_W  read data.
- psel  out  NUM_SLV  one-hot APB select.
- penable, pwrite  out  1  APB enable and direction.
- paddr  out  ADDR_W  APB address: the full latched haddr.
- pwdata  out  DATA_W  APB write data.
- prdata  in  NUM_SLV*DATA_W  slave i read data at [i*DATA_W +: DATA_W].
- pready, pslverr  in  NUM_SLV  per-slave ready and error.

## Operation
- Accept condition: hsel & htrans[1] & hreadyin & hready, sampled in IDLE or ERR2.
- Hit condition: haddr upper bits equal BASE_ADDR, and idx = haddr[SLV_AW+IDXW-1:SLV_AW] < NUM_SLV.
- On accept, haddr, hwrite, and idx are latched.
- States:
  - IDLE: hready=1, no APB select. Accept + miss -> ERR1. Accept + hit + read -> SETUP. Accept + hit + write -> WDATA. Otherwise stay.
  - WDATA: hready=0. Capture hwdata into pwdata -> SETUP.
  - SETUP: psel[idx]=1, penable=0; paddr and pwrite valid; hready=0 -> ACCESS.
  - ACCESS: psel[idx]=1, penable=1, hready=0.
    - pready[idx]=1 and pslverr[idx]=0 -> IDLE. If read, load hrdata from the prdata[idx] slice.
    - pready[idx]=1 and pslverr[idx]=1 -> ERR1.
    - pready[idx]=0 on ACCESS cycle number TIMEOUT (TIMEOUT>0) -> ERR1.
    - Otherwise stay in ACCESS. The timeout counter increments each ACCESS cycle and clears on SETUP.
  - ERR1: psel=0, penable=0, hresp=1, hready=0 -> ERR2.
  - ERR2: hresp=1, hready=1. Accepts a new transfer exactly as IDLE does; otherwise -> IDLE.
- pready and pslverr of unselected slaves are ignored.
- When pready rises on the same cycle the timeout would fire, pready wins.
- htrans IDLE/BUSY and hsel=0 are ignored, with OKAY response.
- hrdata holds its last read value until the next successful read. It is never updated on writes or errors.
- paddr, pwrite, and pwdata hold their last values after a transfer. psel and penable are deasserted.

## Timing
- Reset values: all outputs 0 except hready=1. State is IDLE, timeout counter is 0.
- Reset mid-transfer: at the next edge, psel and penable drop and the pending AHB transfer is abandoned; no hresp is issued.
- Read, zero wait, address phase in cycle 0:
  - cycle 1 SETUP.
  - cycle 2 ACCESS with pready=1.
  - cycle 3 hready=1, hrdata valid.
  - Data phase is 3 cycles (2 wait states).
- Write, zero wait: cycle 1 WDATA, cycle 2 SETUP, cycle 3 ACCESS, cycle 4 hready=1.
- Each pready=0 cycle adds one cycle.
- Error response, measured from ERR1 entry: ERR1 gives hresp=1 with hready=0; the next cycle gives hresp=1 with hready=1.
- Back-to-back: a new address sampled in the hready=1 completion cycle starts SETUP or WDATA on the next cycle. There are no idle gaps on APB beyond the mandatory setup.

## Test plan
- Read slave 2: haddr=0x4000_2010, prdata[2]=0xCAFE_0001, pready=1. Expect psel=4'b0100 in cycles 1-2, penable only in cycle 2, paddr=0x4000_2010. Cycle 3: hrdata=0xCAFE_0001, hready=1, hresp=0.
- Write slave 0: haddr=0x4000_0004, hwdata=0x1234_5678. Expect pwrite=1 and pwdata=0x1234_5678 from SETUP (cycle 2) through ACCESS. hready=1 in cycle 4.
- Wait states plus error: slave 1 holds pready=0 for 3 ACCESS cycles, then pready=1 and pslverr=1. Expect 4 ACCESS cycles, then ERR1 (hresp=1, hready=0), then ERR2 (hresp=1, hready=1). hrdata is unchanged.
- Decode miss: haddr=0x5000_0000, and separately idx=NUM_SLV when NUM_SLV=3. Expect no psel activity and an immediate two-cycle ERROR.
- Timeout, TIMEOUT=4: pready stuck at 0. Expect exactly 4 ACCESS cycles, then the ERROR sequence. A back-to-back read accepted in ERR2 completes normally.
- Reset: assert hreset during ACCESS. At the next edge expect psel=0, penable=0, hready=1, hresp=0, hrdata=0.

Source files
------------

// File: rtl/ahb2apb_bridge_mp.sv
// AHB slave to multi-slave APB3 bridge: decodes one window per APB slave, inserts
// pready wait states, turns pslverr or a pready timeout into a two-cycle AHB ERROR.
module ahb2apb_bridge_mp #(
    parameter int                 ADDR_W    = 32,
    parameter int                 DATA_W    = 32,
    parameter int                 NUM_SLV   = 4,
    parameter int                 SLV_AW    = 12,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = ADDR_W'(32'h4000_0000),
    parameter int                 TIMEOUT   = 16
) (
    input  logic                      hclk,
    input  logic                      hreset,
    input  logic                      hsel,
    input  logic                      hwrite,
    input  logic                      hreadyin,
    input  logic [1:0]                htrans,
    input  logic [ADDR_W-1:0]         haddr,
    input  logic [DATA_W-1:0]         hwdata,
    output logic                      hready,
    output logic                      hresp,
    output logic [DATA_W-1:0]         hrdata,
    output logic [NUM_SLV-1:0]        psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDR_W-1:0]         paddr,
    output logic [DATA_W-1:0]         pwdata,
    input  logic [NUM_SLV*DATA_W-1:0] prdata,
    input  logic [NUM_SLV-1:0]        pready,
    input  logic [NUM_SLV-1:0]        pslverr
);
    localparam int IDXW   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int NPAD   = 1 << IDXW;
    localparam int TW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int HI_LSB = SLV_AW + IDXW;

    typedef enum logic [2:0] {
        S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
    } state_t;

    state_t              state_q, state_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic [TW-1:0]       tout_q, tout_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [DATA_W-1:0]   hrdata_q, hrdata_d;
    logic                hready_q, hready_d;
    logic                hresp_q, hresp_d;
    logic [NUM_SLV-1:0]  psel_q, psel_d;
    logic                penable_q, penable_d;

    // Pad per-slave inputs to a power of two so idx never selects out of range.
    logic [NPAD-1:0]     pready_pad, pslverr_pad;
    logic [DATA_W-1:0]   prdata_arr [NPAD];

    for (genvar gi = 0; gi < NPAD; gi++) begin : g_pad
        if (gi < NUM_SLV) begin : g_real
            assign pready_pad[gi]  = pready[gi];
            assign pslverr_pad[gi] = pslverr[gi];
            assign prdata_arr[gi]  = prdata[gi*DATA_W +: DATA_W];
        end else begin : g_fill
            assign pready_pad[gi]  = 1'b0;
            assign pslverr_pad[gi] = 1'b0;
            assign prdata_arr[gi]  = '0;
        end
    end

    logic [IDXW-1:0] haddr_idx;
    logic            hit, accept, sel_ready, sel_err, tout_hit;
    logic            unused_htrans0;

    assign unused_htrans0 = htrans[0];
    assign haddr_idx = haddr[HI_LSB-1:SLV_AW];
    assign hit       = (haddr[ADDR_W-1:HI_LSB] == BASE_ADDR[ADDR_W-1:HI_LSB]) &&
                       ({1'b0, haddr_idx} < (IDXW+1)'(NUM_SLV));
    assign accept    = hsel & htrans[1] & hreadyin & hready_q;
    assign sel_ready = pready_pad[idx_q];
    assign sel_err   = pslverr_pad[idx_q];
    assign tout_hit  = (TIMEOUT != 0) && (tout_q == TW'(TIMEOUT - 1));

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            tout_q    <= '0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            hrdata_q  <= '0;
            hready_q  <= 1'b1;
            hresp_q   <= 1'b0;
            psel_q    <= '0;
            penable_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tout_q    <= tout_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            hrdata_q  <= hrdata_d;
            hready_q  <= hready_d;
            hresp_q   <= hresp_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tout_d   = tout_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        case (state_q)
            S_IDLE, S_ERR2: begin
                state_d = S_IDLE;
                if (accept) begin
                    idx_d    = haddr_idx;
                    paddr_d  = haddr;
                    pwrite_d = hwrite;
                    if (!hit)        state_d = S_ERR1;
                    else if (hwrite) state_d = S_WDATA;
                    else             state_d = S_SETUP;
                end
            end
            S_WDATA: state_d = S_SETUP;
            S_SETUP: begin
                tout_d  = '0;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                tout_d = tout_q + 1'b1;
                // A late pready on the timeout cycle still completes the transfer.
                if (sel_ready)     state_d = sel_err ? S_ERR1 : S_IDLE;
                else if (tout_hit) state_d = S_ERR1;
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        hready_d  = (state_d == S_IDLE) || (state_d == S_ERR2);
        hresp_d   = (state_d == S_ERR1) || (state_d == S_ERR2);
        penable_d = (state_d == S_ACCESS);
        psel_d    = '0;
        if ((state_d == S_SETUP) || (state_d == S_ACCESS))
            psel_d = NUM_SLV'(1) << idx_d;
        pwdata_d  = (state_q == S_WDATA) ? hwdata : pwdata_q;
        hrdata_d  = hrdata_q;
        if ((state_q == S_ACCESS) && sel_ready && !sel_err && !pwrite_q)
            hrdata_d = prdata_arr[idx_q];
    end

    assign hready  = hready_q;
    assign hresp   = hresp_q;
    assign hrdata  = hrdata_q;
    assign psel    = psel_q;
    assign penable = penable_q;
    assign pwrite  = pwrite_q;
    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;
endmodule

// File: tb/tb_ahb2apb_bridge_mp.sv
// Bench for ahb2apb_bridge_mp: three APB slaves, timeout of 4, directed and random
// transfers checked cycle by cycle against a transaction-level expectation.
module tb_ahb2apb_bridge_mp;
    localparam int          NS   = 3;
    localparam int          DW   = 32;
    localparam int          TO   = 4;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic              hclk = 1'b0;
    logic              hreset, hsel, hwrite, hreadyin;
    logic [1:0]        htrans;
    logic [31:0]       haddr, hwdata;
    logic              hready, hresp, penable, pwrite;
    logic [31:0]       hrdata, paddr, pwdata;
    logic [NS-1:0]     psel, pready, pslverr;
    logic [NS*DW-1:0]  prdata;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] last_rd;

    ahb2apb_bridge_mp #(
        .ADDR_W(32), .DATA_W(DW), .NUM_SLV(NS), .SLV_AW(12),
        .BASE_ADDR(BASE), .TIMEOUT(TO)
    ) dut (
        .hclk(hclk), .hreset(hreset), .hsel(hsel), .hwrite(hwrite),
        .hreadyin(hreadyin), .htrans(htrans), .haddr(haddr), .hwdata(hwdata),
        .hready(hready), .hresp(hresp), .hrdata(hrdata), .psel(psel),
        .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 hclk = ~hclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    // Windows are 4 KB each; bits [13:12] pick the slave, bits above must match BASE.
    function automatic logic is_hit(input logic [31:0] a);
        return ((a >> 14) == (BASE >> 14)) && (((a >> 12) % 4) < NS);
    endfunction

    task automatic err_seq(input string tag);
        chk({tag, "_err1_hready"}, 64'(hready), 64'd0);
        chk({tag, "_err1_hresp"}, 64'(hresp), 64'd1);
        chk({tag, "_err1_psel"}, 64'(psel), 64'd0);
        chk({tag, "_err1_penable"}, 64'(penable), 64'd0);
        chk({tag, "_err1_hrdata"}, 64'(hrdata), 64'(last_rd));
        step();
        chk({tag, "_err2_hready"}, 64'(hready), 64'd1);
        chk({tag, "_err2_hresp"}, 64'(hresp), 64'd1);
        chk({tag, "_err2_psel"}, 64'(psel), 64'd0);
        chk({tag, "_err2_hrdata"}, 64'(hrdata), 64'(last_rd));
    endtask

    // Starts in a cycle where the bridge shows hready=1 and ends in the next such cycle.
    task automatic xfer(input string tag, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wd, input int waits, input logic serr,
                        input logic [31:0] rd);
        logic          hit;
        int            idx;
        logic [NS-1:0] onehot;
        bit            done, err;
        hit    = is_hit(addr);
        idx    = int'((addr >> 12) % 4);
        onehot = hit ? NS'(1 << idx) : '0;
        $display("xfer %s addr=%08h wr=%0d waits=%0d serr=%0d hit=%0d", tag, addr, wr, waits, serr, hit);
        chk({tag, "_addr_hready"}, 64'(hready), 64'd1);
        hsel     = 1'b1;
        htrans   = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b11;
        haddr    = addr;
        hwrite   = wr;
        hreadyin = 1'b1;
        prdata   = {$urandom, $urandom, $urandom};
        if (hit) prdata[idx*DW +: DW] = rd;
        step();
        hsel   = 1'b0;
        htrans = 2'b00;
        haddr  = $urandom;
        hwrite = 1'($urandom);
        hwdata = wd;
        if (!hit) begin
            err_seq(tag);
            return;
        end
        if (wr) begin
            chk({tag, "_wdata_hready"}, 64'(hready), 64'd0);
            chk({tag, "_wdata_psel"}, 64'(psel), 64'd0);
            step();
            hwdata = $urandom;
        end
        chk({tag, "_setup_psel"}, 64'(psel), 64'(onehot));
        chk({tag, "_setup_penable"}, 64'(penable), 64'd0);
        chk({tag, "_setup_paddr"}, 64'(paddr), 64'(addr));
        chk({tag, "_setup_pwrite"}, 64'(pwrite), 64'(wr));
        chk({tag, "_setup_hready"}, 64'(hready), 64'd0);
        if (wr) chk({tag, "_setup_pwdata"}, 64'(pwdata), 64'(wd));
        pready  = NS'($urandom);
        pslverr = NS'($urandom);
        step();
        done = 1'b0;
        err  = 1'b0;
        for (int n = 1; n <= TO && !done; n++) begin
            chk({tag, "_access_psel"}, 64'(psel), 64'(onehot));
            chk({tag, "_access_penable"}, 64'(penable), 64'd1);
            chk({tag, "_access_hready"}, 64'(hready), 64'd0);
            chk({tag, "_access_paddr"}, 64'(paddr), 64'(addr));
            if (wr) chk({tag, "_access_pwdata"}, 64'(pwdata), 64'(wd));
            pready  = NS'($urandom);
            pslverr = NS'($urandom);
            if (n > waits) begin
                pready[idx]  = 1'b1;
                pslverr[idx] = serr;
                done = 1'b1;
                err  = serr;
            end else begin
                pready[idx] = 1'b0;
                if (n == TO) begin
                    done = 1'b1;
                    err  = 1'b1;
                end
            end
            step();
        end
        pready  = '0;
        pslverr = '0;
        if (err) begin
            err_seq(tag);
        end else begin
            if (!wr) last_rd = rd;
            chk({tag, "_done_hready"}, 64'(hready), 64'd1);
            chk({tag, "_done_hresp"}, 64'(hresp), 64'd0);
            chk({tag, "_done_psel"}, 64'(psel), 64'd0);
            chk({tag, "_done_penable"}, 64'(penable), 64'd0);
            chk({tag, "_done_hrdata"}, 64'(hrdata), 64'(last_rd));
        end
    endtask

    // One cycle of bus traffic the bridge must not accept.
    task automatic idle_cycle();
        case ($urandom_range(0, 2))
            0: begin hsel = 1'b0; htrans = 2'($urandom); hreadyin = 1'b1; end
            1: begin hsel = 1'b1; htrans = {1'b0, 1'($urandom)}; hreadyin = 1'b1; end
            default: begin hsel = 1'b1; htrans = 2'b10; hreadyin = 1'b0; end
        endcase
        haddr  = BASE;
        hwrite = 1'($urandom);
        hwdata = $urandom;
        step();
        chk("idle_hready", 64'(hready), 64'd1);
        chk("idle_hresp", 64'(hresp), 64'd0);
        chk("idle_psel", 64'(psel), 64'd0);
        chk("idle_penable", 64'(penable), 64'd0);
        hsel     = 1'b0;
        htrans   = 2'b00;
        hreadyin = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        hreset = 1'b1; hsel = 1'b0; hwrite = 1'b0; hreadyin = 1'b1; htrans = 2'b00;
        haddr = '0; hwdata = '0; prdata = '0; pready = '0; pslverr = '0;
        last_rd = '0;
        repeat (2) @(posedge hclk);
        #1;
        chk("rst_hready", 64'(hready), 64'd1);
        chk("rst_hresp", 64'(hresp), 64'd0);
        chk("rst_hrdata", 64'(hrdata), 64'd0);
        chk("rst_psel", 64'(psel), 64'd0);
        chk("rst_penable", 64'(penable), 64'd0);
        chk("rst_paddr", 64'(paddr), 64'd0);
        chk("rst_pwrite", 64'(pwrite), 64'd0);
        chk("rst_pwdata", 64'(pwdata), 64'd0);
        hreset = 1'b0;
        step();

        xfer("rd_s2", 32'h4000_2010, 1'b0, 32'h0, 0, 1'b0, 32'hCAFE_0001);
        xfer("wr_s0", 32'h4000_0004, 1'b1, 32'h1234_5678, 0, 1'b0, 32'h0);
        xfer("wait_err_s1", 32'h4000_1000, 1'b0, 32'h0, 3, 1'b1, 32'hDEAD_BEEF);
        xfer("miss_base", 32'h5000_0000, 1'b0, 32'h0, 0, 1'b0, 32'h0);
        xfer("miss_idx", 32'h4000_3000, 1'b1, 32'h0BAD_0BAD, 0, 1'b0, 32'h0);
        xfer("timeout_s0", 32'h4000_0100, 1'b0, 32'h0, 100, 1'b0, 32'h1111_2222);
        xfer("b2b_after_err", 32'h4000_1ABC, 1'b0, 32'h0, 0, 1'b0, 32'h8765_4321);
        xfer("wait3_ok_s2", 32'h4000_2FFC, 1'b0, 32'h0, 3, 1'b0, 32'h5A5A_A5A5);
        idle_cycle();
        idle_cycle();

        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = BASE | (32'($urandom_range(0, 3)) << 12) | 32'($urandom_range(0, 4095));
            xfer("rand", a, 1'($urandom), $urandom, int'($urandom_range(0, 5)),
                 ($urandom_range(0, 3) == 0), $urandom);
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) idle_cycle();
        end

        $display("xfer reset_mid_access addr=40001040");
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h4000_1040; hwrite = 1'b0; hreadyin = 1'b1;
        step();
        hsel = 1'b0; htrans = 2'b00; pready = '0; pslverr = '0;
        step();
        chk("rstmid_pre_penable", 64'(penable), 64'd1);
        hreset = 1'b1;
        step();
        chk("rstmid_psel", 64'(psel), 64'd0);
        chk("rstmid_penable", 64'(penable), 64'd0);
        chk("rstmid_hready", 64'(hready), 64'd1);
        chk("rstmid_hresp", 64'(hresp), 64'd0);
        chk("rstmid_hrdata", 64'(hrdata), 64'd0);
        hreset  = 1'b0;
        last_rd = '0;
        xfer("after_reset", 32'h4000_2020, 1'b0, 32'h0, 1, 1'b0, 32'hFEED_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
